// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256/SHA-224 compression engine:
//   - word_t / hstate_t  : 32-bit word and the eight-word state vector
//                          (element 0 = a/H0, packed into the MSBs)
//   - state_e            : engine FSM states
//   - K                  : the 64 round constants
//   - IV256 / IV224      : initial hash values
//   - ch, maj, big_sigma0/1, small_sigma0/1 : round and schedule functions
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Index 0 is the most significant word, so a packed hstate_t lines up
  // directly with the big-endian digest layout (H0 in [255:224]).
  typedef logic [0:7][31:0] hstate_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hstate_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hstate_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // rotr2 ^ rotr13 ^ rotr22
  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // rotr6 ^ rotr11 ^ rotr25
  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // rotr7 ^ rotr18 ^ shr3
  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // rotr17 ^ rotr19 ^ shr10
  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// -----------------------------------------------------------------------------
// sha256_compress_if
// Block-in / digest-out handshake bundle for sha256_compress.
//   in_valid/in_ready   : upstream block handshake
//   in_block            : 512-bit padded block, W0 in [511:480]
//   in_first/in_last    : message framing of the offered block
//   mode                : 0 = SHA-256, 1 = SHA-224 (sampled on first block)
//   out_valid/out_ready : downstream digest handshake
//   out_digest          : H0 in [255:224]
//   busy                : engine not idle
// master = block producer / digest consumer, slave = the engine.
// -----------------------------------------------------------------------------
interface sha256_compress_if;

  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;
  logic         busy;

  modport master (
    output in_valid, in_block, in_first, in_last, mode, out_ready,
    input  in_ready, out_valid, out_digest, busy
  );

  modport slave (
    input  in_valid, in_block, in_first, in_last, mode, out_ready,
    output in_ready, out_valid, out_digest, busy
  );

endinterface

// File: rtl/sha256_round.sv
// -----------------------------------------------------------------------------
// sha256_round
// One purely combinational SHA-256 round.
//   st_i : working variables a..h before the round (a = element 0)
//   k_i  : round constant Kt
//   w_i  : schedule word Wt
//   st_o : working variables after the round
// -----------------------------------------------------------------------------
module sha256_round
  import sha256_pkg::*;
(
  input  hstate_t st_i,
  input  word_t   k_i,
  input  word_t   w_i,
  output hstate_t st_o
);

  word_t t1_s;
  word_t t2_s;

  // T1/T2 and the register rotation a..h -> new a..h
  always_comb begin
    t1_s = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2_s = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o = {t1_s + t2_s, st_i[0], st_i[1], st_i[2],
            st_i[3] + t1_s, st_i[4], st_i[5], st_i[6]};
  end

endmodule

// File: rtl/sha256_compress.sv
// -----------------------------------------------------------------------------
// sha256_compress
// Iterative SHA-256 / SHA-224 compression engine. Accepts one padded 512-bit
// block per transaction, runs 64 rounds at RPC rounds per clock, folds the
// result into the chaining value H and, on the last block of a message,
// presents the digest until the consumer takes it.
//
// Parameters
//   RPC : rounds per clock, one of 1, 2, 4, 8
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   io  : sha256_compress_if.slave (block in, digest out, busy)
//
// Build option
//   SHA256_SHA224_EN : when defined, io.mode selects the SHA-224 IV and zeroes
//                      the low digest word; when undefined, io.mode is ignored
//                      and the engine is SHA-256 only.
//
// Latency from the accept cycle (cycle 0): ROUND in cycles 1..64/RPC, ADD in
// cycle 64/RPC+1, out_valid / in_ready (non-last block) in cycle 64/RPC+2.
// -----------------------------------------------------------------------------
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  sha256_compress_if.slave  io
);

  if ((RPC != 1) && (RPC != 2) && (RPC != 4) && (RPC != 8)) begin : g_bad_rpc
    $error("sha256_compress: RPC must be 1, 2, 4 or 8");
  end

  state_e       state_q, state_d;
  logic [6:0]   t_q, t_d;
  word_t        w_q [0:15];
  word_t        w_d [0:15];
  hstate_t      work_q, work_d;
  hstate_t      h_q, h_d;
  logic [255:0] digest_q, digest_d;
  logic         mode_q, mode_d;
  logic         last_q, last_d;
  logic         in_ready_q, out_valid_q, busy_q;

  logic         mode_s;
  hstate_t      iv_s;
  word_t        ext_s [0:15+RPC];
  hstate_t [RPC:0] chain_s;

`ifdef SHA256_SHA224_EN
  assign mode_s = io.mode;
  assign iv_s   = io.mode ? IV224 : IV256;
`else
  logic mode_unused_s;
  assign mode_unused_s = io.mode;
  assign mode_s        = 1'b0;
  assign iv_s          = IV256;
`endif

  // Schedule extension: w_q always holds W[t..t+15]; append the next RPC
  // words so round r of this cycle uses ext_s[r] and the window slides by RPC.
  // For t<16 this simply consumes block words; later words overwrite nothing
  // that is still needed.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ext_s[i] = w_q[i];
    end
    for (int j = 0; j < RPC; j++) begin
      ext_s[16+j] = small_sigma1(ext_s[14+j]) + ext_s[9+j]
                  + small_sigma0(ext_s[1+j]) + ext_s[j];
    end
  end

  assign chain_s[0] = work_q;

  for (genvar r = 0; r < RPC; r++) begin : g_round
    sha256_round u_round (
      .st_i (chain_s[r]),
      .k_i  (K[t_q[5:0] + 6'(r)]),
      .w_i  (ext_s[r]),
      .st_o (chain_s[r+1])
    );
  end

  // Next-state and datapath update for the IDLE/ROUND/ADD/OUT sequence
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    w_d      = w_q;
    work_d   = work_q;
    h_d      = h_q;
    digest_d = digest_q;
    mode_d   = mode_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = io.in_block[511 - 32*i -: 32];
          end
          last_d  = io.in_last;
          t_d     = 7'd0;
          state_d = ST_ROUND;
          if (io.in_first) begin
            h_d    = iv_s;
            work_d = iv_s;
            mode_d = mode_s;
          end else begin
            work_d = h_q;  // chain from the previous block (or the reset IV)
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUND: begin
        work_d = chain_s[RPC];
        for (int i = 0; i < 16; i++) begin
          w_d[i] = ext_s[i+RPC];
        end
        t_d = t_q + 7'(RPC);
        if (t_q == 7'(64 - RPC)) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < 8; i++) begin
          h_d[i] = h_q[i] + work_q[i];
        end
        t_d = 7'd0;
        if (last_q) begin
          // H7 still chains in full; only the presented digest drops it.
          digest_d = {h_d[0:6], (mode_q ? 32'h00000000 : h_d[7])};
          state_d  = ST_OUT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= 7'd0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'h00000000;
      end
      work_q      <= 256'h0;
      h_q         <= IV256;
      digest_q    <= 256'h0;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      w_q         <= w_d;
      work_q      <= work_d;
      h_q         <= h_d;
      digest_q    <= digest_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_OUT);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // in_ready_q resets high so it is already valid on release; mask it while
  // reset is asserted.
  assign io.in_ready   = in_ready_q & ~rst;
  assign io.out_valid  = out_valid_q;
  assign io.out_digest = digest_q;
  assign io.busy       = busy_q;

endmodule

// File: tb/tb_sha256_compress.sv
// -----------------------------------------------------------------------------
// tb_sha256_compress
// Drives four engines (RPC = 1, 2, 4, 8) with identical stimulus and checks
// digests, output timing, backpressure and mid-operation reset against known
// SHA-256 / SHA-224 answers.
// -----------------------------------------------------------------------------
module tb_sha256_compress;

  localparam int NDUT = 4;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h00000000}}};
  localparam logic [511:0] TWO_BLK0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK1  = {{15{32'h00000000}}, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] DIG_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         mode;
  logic         out_ready;

  logic [NDUT-1:0] in_ready_a;
  logic [NDUT-1:0] out_valid_a;
  logic [NDUT-1:0] busy_a;
  logic [255:0]    out_digest_a [NDUT];

  int checks;
  int errors;

  typedef struct {
    logic [511:0] blk0;
    logic [511:0] blk1;
    int           nblk;
    logic         first;
    logic         md;
    logic [255:0] dig;
  } vec_t;

  vec_t vecs [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sha256_compress_if u_if ();
    assign u_if.in_valid  = in_valid;
    assign u_if.in_block  = in_block;
    assign u_if.in_first  = in_first;
    assign u_if.in_last   = in_last;
    assign u_if.mode      = mode;
    assign u_if.out_ready = out_ready;
    assign in_ready_a[g]   = u_if.in_ready;
    assign out_valid_a[g]  = u_if.out_valid;
    assign busy_a[g]       = u_if.busy;
    assign out_digest_a[g] = u_if.out_digest;

    sha256_compress #(.RPC(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .io  (u_if.slave)
    );
  end

  task automatic check(input string nm, input int g, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rpc=%0d: got %h expected %h", nm, 1 << g, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int g = 0; g < NDUT; g++) begin
      check({nm, "_in_ready"},  g, 256'(in_ready_a[g]),  256'h0);
      check({nm, "_out_valid"}, g, 256'(out_valid_a[g]), 256'h0);
      check({nm, "_busy"},      g, 256'(busy_a[g]),      256'h0);
      check({nm, "_digest"},    g, out_digest_a[g],      256'h0);
    end
  endtask

  // Offer one block to all engines, then watch 72 cycles for the first
  // out_valid and the return of in_ready on each engine.
  task automatic run_block(input string nm, input logic [511:0] blk, input logic first,
                           input logic last, input logic md, input logic [255:0] dig);
    int first_ov [NDUT];
    int first_rdy [NDUT];
    logic [255:0] dig_at [NDUT];
    int lat;
    @(negedge clk);
    in_block = blk;
    in_first = first;
    in_last  = last;
    mode     = md;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      first_ov[g]  = 0;
      first_rdy[g] = 0;
      dig_at[g]    = 256'h0;
    end
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (out_valid_a[g] && (first_ov[g] == 0)) begin
          first_ov[g] = c;
          dig_at[g]   = out_digest_a[g];
        end
        if (in_ready_a[g] && (first_rdy[g] == 0)) begin
          first_rdy[g] = c;
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      lat = 64 >> g;
      check({nm, "_ov_cycle"}, g, 256'(first_ov[g]), last ? 256'(lat + 2) : 256'h0);
      check({nm, "_rdy_cycle"}, g, 256'(first_rdy[g]), last ? 256'(lat + 3) : 256'(lat + 2));
      if (last) begin
        check({nm, "_digest"}, g, dig_at[g], dig);
      end
    end
  endtask

  initial begin
    int bad_dig [NDUT];
    int bad_rdy [NDUT];
    int bad_ov [NDUT];

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_block  = 512'h0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;

    // abc with first=0 right after reset chains from the SHA-256 IV.
    vecs[0] = '{blk0: ABC_BLK,   blk1: ABC_BLK,  nblk: 1, first: 1'b0, md: 1'b0, dig: DIG_ABC};
    vecs[1] = '{blk0: EMPTY_BLK, blk1: ABC_BLK,  nblk: 1, first: 1'b1, md: 1'b0, dig: DIG_EMPTY};
    vecs[2] = '{blk0: TWO_BLK0,  blk1: TWO_BLK1, nblk: 2, first: 1'b1, md: 1'b0, dig: DIG_TWO};
`ifdef SHA256_SHA224_EN
    vecs[3] = '{blk0: ABC_BLK,   blk1: ABC_BLK,  nblk: 1, first: 1'b1, md: 1'b1, dig: DIG_224};
`else
    vecs[3] = '{blk0: ABC_BLK,   blk1: ABC_BLK,  nblk: 1, first: 1'b1, md: 1'b1, dig: DIG_ABC};
`endif
    vecs[4] = '{blk0: ABC_BLK,   blk1: ABC_BLK,  nblk: 1, first: 1'b1, md: 1'b0, dig: DIG_ABC};

    // Reset state
    #2;
    check_reset_outputs("rst_hold");
    #20;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("rdy_after_rst", g, 256'(in_ready_a[g]), 256'h1);
      check("busy_after_rst", g, 256'(busy_a[g]), 256'h0);
    end

    // Table of messages
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].nblk == 2) begin
        run_block($sformatf("vec%0d_b0", v), vecs[v].blk0, vecs[v].first, 1'b0, vecs[v].md, vecs[v].dig);
        run_block($sformatf("vec%0d_b1", v), vecs[v].blk1, 1'b0, 1'b1, vecs[v].md, vecs[v].dig);
      end else begin
        run_block($sformatf("vec%0d", v), vecs[v].blk0, vecs[v].first, 1'b1, vecs[v].md, vecs[v].dig);
      end
    end

    // Backpressure: digest held, in_valid ignored while OUT
    out_ready = 1'b0;
    @(negedge clk);
    in_block = ABC_BLK;
    in_first = 1'b1;
    in_last  = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (70) @(negedge clk);
    in_block = EMPTY_BLK;
    in_valid = 1'b1;
    for (int g = 0; g < NDUT; g++) begin
      bad_dig[g] = 0;
      bad_rdy[g] = 0;
      bad_ov[g]  = 0;
    end
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (out_digest_a[g] !== DIG_ABC) bad_dig[g]++;
        if (in_ready_a[g] !== 1'b0) bad_rdy[g]++;
        if (out_valid_a[g] !== 1'b1) bad_ov[g]++;
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      check("hold_digest_cycles", g, 256'(bad_dig[g]), 256'h0);
      check("hold_rdy_cycles", g, 256'(bad_rdy[g]), 256'h0);
      check("hold_ov_cycles", g, 256'(bad_ov[g]), 256'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("release_in_ready", g, 256'(in_ready_a[g]), 256'h1);
      check("release_out_valid", g, 256'(out_valid_a[g]), 256'h0);
      check("release_digest_held", g, out_digest_a[g], DIG_ABC);
    end
    repeat (5) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("ignored_block_busy", g, 256'(busy_a[g]), 256'h0);
    end

    // Reset at round ~30 aborts the message
    @(negedge clk);
    in_block = ABC_BLK;
    in_first = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("midround_busy_before", 0, 256'(busy_a[0]), 256'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midround_rst");
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check("midround_rdy_after", g, 256'(in_ready_a[g]), 256'h1);
      check("midround_no_out", g, 256'(out_valid_a[g]), 256'h0);
    end
    run_block("after_rst_abc", ABC_BLK, 1'b1, 1'b1, 1'b0, DIG_ABC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
